// File: rtl/out_buff_arbiter_pkg.sv
// Shared types and helpers for the output-buffer link arbiter.
package out_buff_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BURST
  } arb_state_t;

  localparam int NUM_BUFF_DEF  = 4;
  localparam int MAX_BURST_DEF = 4;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_buff_arbiter_if.sv
// Buffer-side bundle: empty/mask flags in, read enables and select out.
interface out_buff_arbiter_if
  import out_buff_arbiter_pkg::*;
#(
  parameter int NUM_BUFF = NUM_BUFF_DEF
);
  localparam int LW = idx_w(NUM_BUFF);

  logic [NUM_BUFF-1:0] I_Empty;
  logic [NUM_BUFF-1:0] I_Mask;
  logic [NUM_BUFF-1:0] O_Re;
  logic [LW-1:0]       O_Sel;
  logic                O_Valid;
  logic                O_Busy;

  modport master (
    output I_Empty, I_Mask,
    input  O_Re, O_Sel, O_Valid, O_Busy
  );

  modport slave (
    input  I_Empty, I_Mask,
    output O_Re, O_Sel, O_Valid, O_Busy
  );

endinterface

// File: rtl/out_buff_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after i_Ptr.
module out_buff_arbiter_rr_pick
  import out_buff_arbiter_pkg::*;
#(
  parameter int N  = NUM_BUFF_DEF,
  parameter int LW = idx_w(N)
) (
  input  logic [N-1:0]  i_Req,
  input  logic [LW-1:0] i_Ptr,
  output logic          o_Found,
  output logic [LW-1:0] o_Idx
);

  logic [N-1:0]  w_rot;
  logic [LW-1:0] w_off;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_Req[LW'((k + int'(i_Ptr)) % N)];
    end
  end

  // Scan downward so the lowest rotated offset wins.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = LW'(k);
    end
  end

  assign o_Found = |w_rot;
  assign o_Idx   = LW'((int'(w_off) + int'(i_Ptr)) % N);

endmodule

// File: rtl/out_buff_arbiter.sv
// Round-robin burst scheduler sharing one output link among NUM_BUFF buffers.
module out_buff_arbiter
  import out_buff_arbiter_pkg::*;
#(
  parameter int NUM_BUFF     = NUM_BUFF_DEF,
  parameter int LOG_NUM_BUFF = idx_w(NUM_BUFF),
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int LOG_BURST    = $clog2(MAX_BURST + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Active,
  input  logic               I_Clr,
  input  logic               I_Nack,
  out_buff_arbiter_if.slave  bus
);

  localparam logic [LOG_NUM_BUFF-1:0] LAST_IDX =
    LOG_NUM_BUFF'(NUM_BUFF - 1);
  localparam logic [LOG_BURST-1:0] LAST_BEAT =
    LOG_BURST'(MAX_BURST - 1);

  arb_state_t r_State, w_NState;
  logic [LOG_NUM_BUFF-1:0] r_Sel, w_NSel;
  logic [LOG_NUM_BUFF-1:0] r_Ptr, w_NPtr;
  logic [LOG_BURST-1:0]    r_Cnt, w_NCnt;

  logic [NUM_BUFF-1:0]     w_Req;
  logic [NUM_BUFF-1:0]     w_Re;
  logic [LOG_NUM_BUFF-1:0] w_Idx;
  logic [LOG_NUM_BUFF-1:0] w_SelInc;
  logic w_Found, w_ReqSel, w_Rd, w_Last, w_Burst;

  assign w_Req    = ~bus.I_Empty & bus.I_Mask;
  assign w_ReqSel = w_Req[r_Sel];
  assign w_Burst  = (r_State == ST_BURST);
  assign w_Last   = (r_Cnt == LAST_BEAT);
  assign w_SelInc = (r_Sel == LAST_IDX) ? '0
                  : r_Sel + LOG_NUM_BUFF'(1);

  // Nack is not retimed: it gates the read in the same cycle.
  assign w_Rd = w_Burst & w_ReqSel & ~I_Nack
              & I_Active & ~I_Clr & ~reset;

  out_buff_arbiter_rr_pick #(
    .N  (NUM_BUFF),
    .LW (LOG_NUM_BUFF)
  ) u_pick (
    .i_Req   (w_Req),
    .i_Ptr   (r_Ptr),
    .o_Found (w_Found),
    .o_Idx   (w_Idx)
  );

  always_comb begin
    w_NState = r_State;
    w_NSel   = r_Sel;
    w_NPtr   = r_Ptr;
    w_NCnt   = r_Cnt;
    if (I_Clr) begin
      w_NState = ST_IDLE;
      w_NPtr   = '0;
      w_NCnt   = '0;
    end else begin
      unique case (r_State)
        ST_IDLE: begin
          if (I_Active && w_Found) begin
            w_NSel   = w_Idx;
            w_NCnt   = '0;
            w_NState = ST_BURST;
          end
        end
        ST_BURST: begin
          unique case (1'b1)
            !w_ReqSel: begin
              w_NState = ST_IDLE;
              w_NPtr   = w_SelInc;
            end
            w_Rd && w_Last: begin
              w_NState = ST_IDLE;
              w_NPtr   = w_SelInc;
              w_NCnt   = '0;
            end
            w_Rd && !w_Last: begin
              w_NCnt = r_Cnt + LOG_BURST'(1);
            end
            default: ;
          endcase
        end
        default: w_NState = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_State <= ST_IDLE;
      r_Sel   <= '0;
      r_Ptr   <= '0;
      r_Cnt   <= '0;
    end else begin
      r_State <= w_NState;
      r_Sel   <= w_NSel;
      r_Ptr   <= w_NPtr;
      r_Cnt   <= w_NCnt;
    end
  end

  always_comb begin
    w_Re        = '0;
    w_Re[r_Sel] = w_Rd;
  end

  assign bus.O_Re    = w_Re;
  assign bus.O_Sel   = r_Sel;
  assign bus.O_Valid = w_Rd;
  assign bus.O_Busy  = w_Burst;

endmodule

// File: tb/tb_out_buff_arbiter.sv
// Directed bench for out_buff_arbiter with a behavioural grant model.
module tb_out_buff_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic I_Active = 1'b1;
  logic I_Clr = 1'b0;
  logic I_Nack = 1'b0;

  out_buff_arbiter_if #(.NUM_BUFF(N)) bus();

  out_buff_arbiter #(
    .NUM_BUFF  (N),
    .MAX_BURST (MB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .I_Active (I_Active),
    .I_Clr    (I_Clr),
    .I_Nack   (I_Nack),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt [N];
  logic [N-1:0] re_s = '0;
  int cyc = 0;
  logic [N-1:0] log_re   [1024];
  logic [1:0]   log_sel  [1024];
  logic         log_busy [1024];

  // Model: which buffer owns the link (-1 none), reads in this grant,
  // where the next search starts, and the last granted index.
  int m_owner = -1;
  int m_reads = 0;
  int m_start = 0;
  int m_sel   = 0;
  bit m_ok    = 0;

  function automatic logic [N-1:0] req_v();
    return ~bus.I_Empty & bus.I_Mask;
  endfunction

  function automatic logic [N-1:0] m_re();
    logic [N-1:0] r;
    logic [N-1:0] one;
    r   = req_v();
    one = 1;
    if (reset || I_Clr || m_owner < 0) return '0;
    if (r[m_owner] && !I_Nack && I_Active) return one << m_owner;
    return '0;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic m_update();
    logic [N-1:0] r;
    logic [N-1:0] rd;
    bit found;
    r  = req_v();
    rd = m_re();
    if (reset) begin
      m_owner = -1; m_start = 0; m_reads = 0; m_sel = 0; m_ok = 1;
    end else if (I_Clr) begin
      m_owner = -1; m_start = 0; m_reads = 0;
    end else if (m_owner < 0) begin
      found = 0;
      if (I_Active) begin
        for (int j = 0; j < N; j++) begin
          int b;
          b = (m_start + j) % N;
          if (!found && r[b]) begin
            found = 1; m_owner = b; m_sel = b; m_reads = 0;
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_start = (m_owner + 1) % N;
      m_owner = -1;
    end else if (rd != '0) begin
      m_reads++;
      if (m_reads == MB) begin
        m_start = (m_owner + 1) % N;
        m_owner = -1;
        m_reads = 0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (m_ok) begin
      check("re",    bus.O_Re,    m_re());
      check("sel",   bus.O_Sel,   m_sel);
      check("valid", bus.O_Valid, |m_re());
      check("busy",  bus.O_Busy,  m_owner >= 0);
    end
    if (cyc < 1024) begin
      log_re[cyc]   = bus.O_Re;
      log_sel[cyc]  = bus.O_Sel;
      log_busy[cyc] = bus.O_Busy;
    end
    re_s = bus.O_Re;
    cyc++;
  end

  task automatic drive();
    for (int i = 0; i < N; i++) bus.I_Empty[i] = (cnt[i] == 0);
  endtask

  // Buffers drain on the edge of a read; Empty follows one cycle later.
  task automatic tick();
    @(posedge clock);
    m_update();
    for (int i = 0; i < N; i++)
      if (re_s[i] === 1'b1 && cnt[i] > 0) cnt[i]--;
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    I_Clr = 1'b0; I_Nack = 1'b0; I_Active = 1'b1;
    bus.I_Mask = '1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic expect_seq(input string nm, input int c0,
                            input logic [3:0] e [], input int len);
    for (int k = 0; k < len; k++)
      check(nm, log_re[c0 + k], e[k]);
  endtask

  initial begin
    int c0;
    int c1;
    logic [3:0] e [];
    bus.I_Mask = '1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive();
    do_reset();
    #1;
    check("rst_re",    bus.O_Re, 0);
    check("rst_sel",   bus.O_Sel, 0);
    check("rst_busy",  bus.O_Busy, 0);
    check("rst_valid", bus.O_Valid, 0);

    // all empty: nothing happens
    c0 = cyc;
    repeat (10) tick();
    for (int k = 0; k < 10; k++) begin
      check("idle_re",   log_re[c0 + k], 0);
      check("idle_busy", log_busy[c0 + k], 0);
    end

    // single buffer with 6 entries
    do_reset();
    cnt[2] = 6; drive();
    c0 = cyc;
    repeat (10) tick();
    e = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
    expect_seq("b2_burst", c0, e, 10);
    cnt[0] = 1; cnt[3] = 1; drive();
    c1 = cyc;
    repeat (3) tick();
    check("ptr_after_b2", log_re[c1 + 1], 4'b1000);

    // full contention: 0,1,2,3,0 with one gap per grant
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 100;
    drive();
    c0 = cyc;
    repeat (25) tick();
    for (int k = 0; k < 25; k++) begin
      logic [3:0] ex;
      ex = (k % 5 == 0) ? 4'h0 : 4'(1 << ((k / 5) % 4));
      check("rr_re", log_re[c0 + k], ex);
      if (k % 5 != 0) check("rr_sel", log_sel[c0 + k], (k / 5) % 4);
    end

    // Nack for 3 cycles after the 2nd read
    do_reset();
    cnt[0] = 100; drive();
    c0 = cyc;
    repeat (3) tick();
    I_Nack = 1'b1;
    repeat (3) tick();
    I_Nack = 1'b0;
    repeat (3) tick();
    e = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    expect_seq("nack", c0, e, 9);
    for (int k = 3; k < 6; k++) begin
      check("nack_busy", log_busy[c0 + k], 1);
      check("nack_sel",  log_sel[c0 + k], 0);
    end

    // clear mid-burst with Sel=2, one read done
    do_reset();
    cnt[2] = 100; drive();
    c0 = cyc;
    repeat (2) tick();
    I_Clr = 1'b1;
    cnt[0] = 100; cnt[1] = 100; cnt[3] = 100; drive();
    tick();
    I_Clr = 1'b0;
    repeat (3) tick();
    e = '{4'h0, 4'h4, 4'h0, 4'h0, 4'h1, 4'h1};
    expect_seq("clr", c0, e, 6);
    check("clr_sel_held", log_sel[c0 + 3], 2);
    check("clr_idle",     log_busy[c0 + 3], 0);

    // mask drop mid-burst on buffer 1
    do_reset();
    cnt[1] = 100; drive();
    c0 = cyc;
    repeat (3) tick();
    bus.I_Mask[1] = 1'b0;
    cnt[2] = 100; cnt[3] = 100; drive();
    repeat (4) tick();
    e = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4};
    expect_seq("mask", c0, e, 7);

    // inactive freezes an ongoing burst
    do_reset();
    cnt[3] = 100; drive();
    c0 = cyc;
    repeat (2) tick();
    I_Active = 1'b0;
    repeat (2) tick();
    I_Active = 1'b1;
    repeat (2) tick();
    e = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8};
    expect_seq("active", c0, e, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/out_buff_arbiter.md
Name: out_buff_arbiter

Overview:
- Round-robin scheduler that shares one downstream output link among NUM_BUFF output ring buffers in a datapath.
- Watches each buffer's Empty flag and issues a one-hot read enable to the selected buffer.
- Drains the selected buffer in bursts of up to MAX_BURST entries, then rotates to the next requester.
- Honours a downstream non-retimed Nack and a synchronous clear.

Parameters:
- NUM_BUFF, 4, number of output buffers sharing the link
- LOG_NUM_BUFF, $clog2(NUM_BUFF), width of the buffer index
- MAX_BURST, 4, maximum reads per grant (>=1)
- LOG_BURST, $clog2(MAX_BURST+1), width of the burst counter

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- I_Active  in  1  module enable; low freezes the block
- I_Clr  in  1  synchronous clear of arbitration state
- I_Nack  in  1  downstream Nack, non-retimed, same-cycle effect
- I_Empty  in  NUM_BUFF  per-buffer Empty flag (registered, updates the cycle after a read)
- I_Mask  in  NUM_BUFF  per-buffer request enable (1 = may request)
- O_Re  out  NUM_BUFF  one-hot read enable to the granted buffer
- O_Sel  out  LOG_NUM_BUFF  granted buffer index (link mux select)
- O_Valid  out  1  a read is issued this cycle (= |O_Re)
- O_Busy  out  1  state is ST_BURST

Behaviour:
- Request vector: Req[i] = ~I_Empty[i] & I_Mask[i].
- Registers and reset/clear values:
  - State: ST_IDLE
  - RRPtr (next start index): 0
  - Sel: 0
  - BurstCnt: 0
  - Outputs after reset: O_Re=0, O_Sel=0, O_Valid=0, O_Busy=0
- Priority of updates: reset > I_Clr > normal operation.
- I_Clr:
  - O_Re is forced to 0 in the same cycle.
  - Next cycle: ST_IDLE, RRPtr=0, BurstCnt=0. Sel is held.
- ST_IDLE:
  - O_Re = 0.
  - If I_Active and |Req: Sel <= first i with Req[i]=1, searching RRPtr, RRPtr+1, ... mod NUM_BUFF.
  - Same transition sets BurstCnt <= 0 and state <= ST_BURST.
- ST_BURST read enable: Rd = Req[Sel] & ~I_Nack & I_Active; O_Re[Sel] = Rd (combinational).
- ST_BURST transitions (all evaluated in the same cycle):
  - Req[Sel]=0 (buffer emptied or masked): go to ST_IDLE without a read, RRPtr <= (Sel+1) mod NUM_BUFF.
  - Rd=1 and BurstCnt==MAX_BURST-1: go to ST_IDLE, RRPtr <= (Sel+1) mod NUM_BUFF, BurstCnt <= 0.
  - Rd=1 otherwise: BurstCnt <= BurstCnt+1, stay in ST_BURST.
  - I_Nack=1 or I_Active=0 (with Req[Sel]=1): hold state, Sel and BurstCnt; no read.
- RRPtr wrap: NUM_BUFF-1 wraps to 0. Index arithmetic is modulo NUM_BUFF, including non-power-of-2 NUM_BUFF.
- Latency:
  - A request seen in ST_IDLE at cycle t gives the first O_Re at t+1.
  - Exactly one idle cycle separates consecutive bursts.
  - Peak link utilisation under contention: MAX_BURST/(MAX_BURST+1).
- Single-entry buffer: read at t; I_Empty rises at t+1; exit happens at t+1 with no over-read.
- MAX_BURST=1: exit after every read, giving pure per-entry round robin.
- O_Sel = Sel at all times, and stays stable while in ST_BURST.
- At most one bit of O_Re is high. O_Re is never high in ST_IDLE or during I_Clr, reset or I_Nack.

Decomposition:
- pkg_en gains typedef enum logic [0:0] {ST_IDLE, ST_BURST} arb_state_t.
- Sub-module rr_pick: combinational round-robin finder.
  - Inputs: Req, RRPtr.
  - Outputs: Found, Idx.
  - Implementation: rotate-by-RRPtr, priority encode, add back modulo NUM_BUFF.
- out_buff_arbiter holds the FSM, counter, pointer and output decode.

Test Plan:
- Reset, then all I_Empty=1, I_Mask=all 1 for 10 cycles -> O_Re=0, O_Valid=0, O_Busy=0 throughout.
- Only buffer 2 non-empty with 6 entries, MAX_BURST=4 -> O_Re=4'b0100 for 4 cycles, 1 idle cycle, 2 more reads, then ST_IDLE; RRPtr=3.
- All 4 buffers continuously non-empty -> grant order 0,1,2,3,0; each grant gives 4 reads followed by 1 gap cycle; O_Sel matches.
- Buffer 0 granted, I_Nack high for 3 cycles after the 2nd read -> O_Re=0 in those cycles; BurstCnt stays 2; 2 more reads after release; Sel stays 0.
- I_Clr pulsed in ST_BURST with Sel=2, BurstCnt=1 -> O_Re=0 that cycle; next cycle ST_IDLE, RRPtr=0; with all buffers requesting, next grant is buffer 0.
- Buffer 1 granted, I_Mask[1] dropped mid-burst -> no read that cycle, ST_IDLE next cycle, RRPtr=2; with buffers 2 and 3 requesting, next grant is buffer 2.
